// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU.
// Sequences each instruction through fetch, decode, execute, memory and
// writeback, and drives the Moore-style control lines for the shared ALU,
// PC, IR, register file and unified memory port.
module multicycle_control #(
  parameter int          CNT_W   = 32,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic [1:0]       pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  // funct is decoded by the ALU control, not by this FSM.
  logic unused_funct;
  assign unused_funct = ^funct;

  // State, sticky illegal flag and retired-instruction counter.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the values from before the edge; combinational blocks use blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next-state decode, illegal-opcode detection and retire counting.
  // NOTE: every variable gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else begin
          case (opcode)
            OP_RTYPE:                  state_d = S_EXEC_R;
            OP_LW, OP_SW:              state_d = S_MEM_ADDR;
            OP_BEQ, OP_BNE:            state_d = S_BRANCH;
            OP_J:                      state_d = S_JUMP;
            OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
            default: begin
              illegal_d = 1'b1;
              state_d   = S_HALT;
            end
          endcase
        end
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXEC_R: state_d = S_ALU_WB;
      S_EXEC_I: state_d = S_ALU_WB;
      S_ALU_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // Moore control decode; FETCH gates the PC/IR loads with mem_ready.
  // Outputs are held at 0 for as long as rst is high, not just after the
  // state register has been cleared.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_source     = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b11;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_op    = 2'b11;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = (opcode == OP_RTYPE);
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          branch_ne     = opcode[0];
        end
        S_JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

  assign illegal_op  = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions from the
// test plan plus a random instruction stream, checked cycle by cycle against
// per-instruction expected control sequences built from the opcode table.
module tb_multicycle_control;

  localparam logic [5:0] TB_HALT_OP = 6'h3F;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
  } ctl_t;

  typedef struct packed {
    logic rdy;
    ctl_t exp;
  } step_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write;
  logic        ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, halted, illegal_op;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] instr_count;
  ctl_t        dut_ctl;

  int          errors = 0;
  int          checks = 0;
  step_t       exp_q[$];
  logic [31:0] model_count;
  logic        model_retires;

  multicycle_control #(.CNT_W(32), .HALT_OP(TB_HALT_OP)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .halted(halted),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  assign dut_ctl = {pc_write, pc_write_cond, branch_ne, pc_source, i_or_d,
                    mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op, halted};

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control word for each phase an instruction passes through.
  function automatic ctl_t w_fetch(logic r);
    ctl_t c = '0;
    c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.pc_write = r; c.ir_write = r;
    return c;
  endfunction
  function automatic ctl_t w_decode();
    ctl_t c = '0; c.alu_src_b = 2'b11; return c;
  endfunction
  function automatic ctl_t w_addr();
    ctl_t c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; return c;
  endfunction
  function automatic ctl_t w_mem(logic wr);
    ctl_t c = '0; c.i_or_d = 1'b1; c.mem_read = ~wr; c.mem_write = wr; return c;
  endfunction
  function automatic ctl_t w_wb(logic from_mem, logic rd);
    ctl_t c = '0;
    c.reg_write = 1'b1; c.mem_to_reg = from_mem; c.reg_dst = rd;
    return c;
  endfunction
  function automatic ctl_t w_exec(logic imm);
    ctl_t c = '0;
    c.alu_src_a = 1'b1;
    c.alu_src_b = imm ? 2'b10 : 2'b00;
    c.alu_op    = imm ? 2'b11 : 2'b10;
    return c;
  endfunction
  function automatic ctl_t w_branch(logic ne);
    ctl_t c = '0;
    c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1;
    c.pc_source = 2'b01; c.branch_ne = ne;
    return c;
  endfunction
  function automatic ctl_t w_jump();
    ctl_t c = '0; c.pc_write = 1'b1; c.pc_source = 2'b10; return c;
  endfunction
  function automatic ctl_t w_halt();
    ctl_t c = '0; c.halted = 1'b1; return c;
  endfunction

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic r, input ctl_t c);
    step_t s;
    s.rdy = r;
    s.exp = c;
    exp_q.push_back(s);
  endtask

  // Builds the expected per-cycle sequence for one instruction.
  // wf / wm: cycles mem_ready stays low in fetch / in the memory access.
  // Halting instructions get n_halt cycles of HALT appended.
  task automatic build(input logic [5:0] op, input int wf, input int wm, input int n_halt);
    exp_q.delete();
    model_retires = 1'b1;
    repeat (wf) push(1'b0, w_fetch(1'b0));
    push(1'b1, w_fetch(1'b1));
    push(rnd_bit(), w_decode());
    if (op == TB_HALT_OP) begin
      model_retires = 1'b0;
      repeat (n_halt) push(rnd_bit(), w_halt());
    end else begin
      case (op)
        6'h00: begin
          push(rnd_bit(), w_exec(1'b0));
          push(rnd_bit(), w_wb(1'b0, 1'b1));
        end
        6'h08, 6'h0C, 6'h0D: begin
          push(rnd_bit(), w_exec(1'b1));
          push(rnd_bit(), w_wb(1'b0, 1'b0));
        end
        6'h23: begin
          push(rnd_bit(), w_addr());
          repeat (wm) push(1'b0, w_mem(1'b0));
          push(1'b1, w_mem(1'b0));
          push(rnd_bit(), w_wb(1'b1, 1'b0));
        end
        6'h2B: begin
          push(rnd_bit(), w_addr());
          repeat (wm) push(1'b0, w_mem(1'b1));
          push(1'b1, w_mem(1'b1));
        end
        6'h04, 6'h05: push(rnd_bit(), w_branch(op[0]));
        6'h02: push(rnd_bit(), w_jump());
        default: begin
          model_retires = 1'b0;
          repeat (n_halt) push(rnd_bit(), w_halt());
        end
      endcase
    end
  endtask

  // Plays n steps: drive mem_ready, sample at the falling edge, advance.
  task automatic play(input int n);
    step_t s;
    for (int i = 0; i < n; i++) begin
      s = exp_q.pop_front();
      mem_ready = s.rdy;
      @(negedge clk);
      check("ctl", 64'(dut_ctl), 64'(s.exp));
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm);
    opcode = op;
    funct  = fn;
    build(op, wf, wm, 20);
    play(exp_q.size());
    if (model_retires) model_count = model_count + 32'd1;
    check("instr_count", 64'(instr_count), 64'(model_count));
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_count = '0;
  endtask

  logic [5:0] legal_ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0C, 6'h0D};

  initial begin
    rst         = 1'b1;
    opcode      = 6'h00;
    funct       = 6'h00;
    mem_ready   = 1'b0;
    model_count = '0;

    // Reset state: everything low, even with mem_ready high in FETCH.
    @(negedge clk);
    check("reset_ctl", 64'(dut_ctl), 64'(ctl_t'('0)));
    check("reset_count", 64'(instr_count), 64'd0);
    check("reset_illegal", 64'(illegal_op), 64'd0);
    mem_ready = 1'b1;
    #1 check("reset_ctl_ready", 64'(dut_ctl), 64'(ctl_t'('0)));
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed test-plan instructions.
    run_instr(6'h00, 6'h20, 0, 0);   // add
    run_instr(6'h23, 6'h00, 0, 2);   // lw with two wait cycles
    run_instr(6'h05, 6'h00, 0, 0);   // bne
    run_instr(6'h04, 6'h00, 0, 0);   // beq
    run_instr(6'h2B, 6'h00, 0, 0);   // sw
    run_instr(6'h02, 6'h00, 0, 0);   // j
    run_instr(6'h0D, 6'h15, 1, 0);   // ori with a fetch wait

    // Random legal instruction stream with random memory waits.
    for (int k = 0; k < 60; k++) begin
      run_instr(legal_ops[$urandom_range(0, 8)], 6'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Asynchronous reset in the middle of a store wait.
    opcode = 6'h2B;
    build(6'h2B, 0, 3, 0);
    play(4);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_ctl", 64'(dut_ctl), 64'(ctl_t'('0)));
    check("abort_count", 64'(instr_count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_count = '0;
    mem_ready   = 1'b1;
    #1;
    check("post_abort_fetch", 64'(dut_ctl), 64'(w_fetch(1'b1)));
    check("post_abort_count", 64'(instr_count), 64'd0);
    run_instr(6'h08, 6'h00, 0, 0);   // addi after recovery

    // Illegal opcode: halts and stays halted.
    run_instr(6'h3A, 6'h00, 0, 0);
    check("illegal_flag", 64'(illegal_op), 64'd1);
    check("illegal_halted", 64'(halted), 64'd1);

    // Explicit halt opcode: halts without flagging illegal.
    pulse_reset();
    check("illegal_cleared", 64'(illegal_op), 64'd0);
    run_instr(6'h00, 6'h22, 0, 0);
    run_instr(TB_HALT_OP, 6'h3F, 0, 0);
    check("halt_op_illegal", 64'(illegal_op), 64'd0);
    check("halt_op_halted", 64'(halted), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
